// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states and requester ids.
package ram_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic SEL_CPU = 1'b0;
   localparam logic SEL_DBG = 1'b1;
endpackage

// File: rtl/ram_arb_prio.sv
// Winner select: CPU has priority; after MAX_CPU_BURST CPU grants with debug waiting,
// the debug port wins once. Combinational sel, registered burst counter.
module ram_arb_prio
   import ram_arb_pkg::*;
#(
   parameter int MAX_CPU_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic dbg_req,
   input  logic grant_strobe,
   input  logic arb_idle,
   output logic sel
);
   localparam int CW = $clog2(MAX_CPU_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CPU_BURST);

   logic [CW-1:0] burst_cnt_q, burst_cnt_d;

   always_comb begin
      sel         = SEL_CPU;
      burst_cnt_d = burst_cnt_q;
      if (dbg_req && (!cpu_req || burst_cnt_q == CNT_MAX)) begin
         sel = SEL_DBG;
      end
      // Count only CPU grants that made the debug port wait.
      if (arb_idle) begin
         if (!dbg_req) begin
            burst_cnt_d = '0;
         end else if (grant_strobe) begin
            if (sel == SEL_DBG) begin
               burst_cnt_d = '0;
            end else if (burst_cnt_q != CNT_MAX) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares single-port RAM_B between CPU and debug loader: IDLE->ISSUE->DONE, ack two
// cycles after the request is sampled; the losing requester simply keeps req asserted.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW            = 10,
   parameter int DW            = 32,
   parameter int MAX_CPU_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);
   state_t        state_q, state_d;
   logic          win_q, win_d;
   logic          win_wr_q, win_wr_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_din_q, ram_din_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dbg_ack_q, dbg_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
   logic          sel;
   logic          any_req;

   assign any_req = cpu_req | dbg_req;

   ram_arb_prio #(.MAX_CPU_BURST(MAX_CPU_BURST)) u_prio (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .dbg_req      (dbg_req),
      .grant_strobe ((state_q == ST_IDLE) && any_req),
      .arb_idle     (state_q == ST_IDLE),
      .sel          (sel)
   );

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      win_wr_d    = win_wr_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               win_d   = sel;
               state_d = ST_ISSUE;
               if (sel == SEL_DBG) begin
                  win_wr_d   = dbg_we;
                  ram_we_d   = dbg_we;
                  ram_addr_d = dbg_addr;
                  ram_din_d  = dbg_wdata;
               end else begin
                  win_wr_d   = cpu_we;
                  ram_we_d   = cpu_we;
                  ram_addr_d = cpu_addr;
                  ram_din_d  = cpu_wdata;
               end
            end
         end
         ST_ISSUE: begin
            ram_we_d = 1'b0;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            // ram_dout is valid now; capture it alongside the ack so both land together.
            if (win_q == SEL_DBG) begin
               dbg_ack_d = 1'b1;
               if (!win_wr_q) dbg_rdata_d = ram_dout;
            end else begin
               cpu_ack_d = 1'b1;
               if (!win_wr_q) cpu_rdata_d = ram_dout;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         win_q       <= SEL_CPU;
         win_wr_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         win_wr_q    <= win_wr_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random two-port traffic,
// with a queue scoreboard checked by an independent ack monitor.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [9:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_ack;
   logic [9:0]  dbg_addr;
   logic [31:0] dbg_wdata, dbg_rdata;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_din, ram_dout;

   ram_port_arbiter #(.AW(10), .DW(32), .MAX_CPU_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data one cycle after the issue cycle.
   logic [31:0] mem [0:1023];
   logic        mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   typedef struct packed {
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t        cpu_q[$];
   exp_t        dbg_q[$];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] cpu_last, dbg_last;
   logic [31:0] seq_cpu_exp, seq_dbg_exp;
   logic        seq_mode;
   logic        seq_log[$];
   logic        we_prev;
   int          we_cnt;
   int          vectors;
   int          miscompares;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every ack and checks both read-data ports.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         cpu_last = 32'h0;
         dbg_last = 32'h0;
         we_prev  = 1'b0;
      end else begin
         if (ram_we) we_cnt++;
         if (ram_we && we_prev) chk("ram_we_pulse", 32'(ram_we), 32'h0);
         we_prev = ram_we;
         if (cpu_ack) begin
            if (seq_mode) begin
               seq_log.push_back(SEL_CPU);
               cpu_last = seq_cpu_exp;
            end else if (cpu_q.size() == 0) begin
               chk("cpu_unexpected_ack", 32'(cpu_ack), 32'h0);
            end else begin
               e = cpu_q.pop_front();
               if (!e.we) cpu_last = e.data;
            end
            chk("cpu_rdata", cpu_rdata, cpu_last);
            chk("dbg_rdata_hold", dbg_rdata, dbg_last);
         end
         if (dbg_ack) begin
            if (seq_mode) begin
               seq_log.push_back(SEL_DBG);
               dbg_last = seq_dbg_exp;
            end else if (dbg_q.size() == 0) begin
               chk("dbg_unexpected_ack", 32'(dbg_ack), 32'h0);
            end else begin
               e = dbg_q.pop_front();
               if (!e.we) dbg_last = e.data;
            end
            chk("dbg_rdata", dbg_rdata, dbg_last);
            chk("cpu_rdata_hold", cpu_rdata, cpu_last);
         end
      end
   end

   // Drivers: called #1 after a rising edge; return #1 after the ack edge with req dropped.
   task automatic cpu_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                          input logic early_drop, output int lat);
      exp_t e;
      e.we   = we;
      e.data = we ? 32'h0 : ref_mem[a];
      if (we) ref_mem[a] = d;
      cpu_q.push_back(e);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (early_drop) cpu_req = 1'b0;
      end while (!cpu_ack && lat < 60);
      cpu_req = 1'b0;
      if (!cpu_ack) chk("cpu_ack_timeout", 32'(lat), 32'h0);
   endtask

   task automatic dbg_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                          output int lat);
      exp_t e;
      e.we   = we;
      e.data = we ? 32'h0 : ref_mem[a];
      if (we) ref_mem[a] = d;
      dbg_q.push_back(e);
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!dbg_ack && lat < 60);
      dbg_req = 1'b0;
      if (!dbg_ack) chk("dbg_ack_timeout", 32'(lat), 32'h0);
   endtask

   int lat_a, lat_b, w0;

   initial begin
      vectors = 0; miscompares = 0; we_cnt = 0; seq_mode = 1'b0;
      rst = 1'b1; mem_clr = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      chk("rst_ram_we",   32'(ram_we), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_din",  ram_din, 32'h0);
      chk("rst_cpu_ack",  32'(cpu_ack), 32'h0);
      chk("rst_dbg_ack",  32'(dbg_ack), 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Write then read back on the CPU port.
      w0 = we_cnt;
      cpu_txn(1'b1, 10'h005, 32'hDEADBEEF, 1'b0, lat_a);
      chk("t1_wr_latency", 32'(lat_a), 32'd3);
      chk("t1_we_cycles", 32'(we_cnt - w0), 32'd1);
      w0 = we_cnt;
      cpu_txn(1'b0, 10'h005, 32'h0, 1'b0, lat_a);
      chk("t1_rd_latency", 32'(lat_a), 32'd3);
      chk("t1_rd_no_we", 32'(we_cnt - w0), 32'd0);
      chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);

      // Simultaneous requests: CPU first, debug three cycles later.
      dbg_txn(1'b1, 10'h010, 32'hA5A50010, lat_b);
      fork
         cpu_txn(1'b1, 10'h020, 32'h0BADF00D, 1'b0, lat_a);
         dbg_txn(1'b0, 10'h010, 32'h0, lat_b);
      join
      chk("t2_cpu_latency", 32'(lat_a), 32'd3);
      chk("t2_dbg_latency", 32'(lat_b), 32'd6);
      chk("t2_dbg_rdata", dbg_rdata, 32'hA5A50010);

      // Debug write visible to a later CPU read; debug read data untouched.
      dbg_txn(1'b1, 10'h3FF, 32'h12345678, lat_b);
      cpu_txn(1'b0, 10'h3FF, 32'h0, 1'b0, lat_a);
      chk("t4_cpu_rdata", cpu_rdata, 32'h12345678);
      chk("t4_dbg_rdata_hold", dbg_rdata, 32'hA5A50010);

      // Reset in the ISSUE cycle of a CPU write.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0C0; cpu_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk("t5_we_in_issue", 32'(ram_we), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_ram_we", 32'(ram_we), 32'h0);
      chk("t5_rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("t5_rst_cpu_ack", 32'(cpu_ack), 32'h0);
      chk("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      cpu_txn(1'b0, 10'h0C0, 32'h0, 1'b0, lat_a);
      chk("t5_post_rst_latency", 32'(lat_a), 32'd3);

      // Request dropped during ISSUE still completes.
      cpu_txn(1'b0, 10'h005, 32'h0, 1'b1, lat_a);
      chk("t6_latency", 32'(lat_a), 32'd3);
      chk("t6_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_txn(1'b1, 10'h006, 32'h66666666, 1'b0, lat_a);
      chk("t6_next_latency", 32'(lat_a), 32'd3);

      // Random concurrent traffic on disjoint halves of the address space.
      fork
         begin
            int l;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               cpu_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)), $urandom, 1'b0, l);
            end
         end
         begin
            int l;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               dbg_txn(1'($urandom_range(0, 1)), 10'(512 + $urandom_range(0, 511)), $urandom, l);
            end
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      chk("rand_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
      chk("rand_dbg_q_empty", 32'(dbg_q.size()), 32'd0);

      // Both held: debug gets every (MAX_CPU_BURST+1)-th grant.
      seq_cpu_exp = ref_mem[10'h0AA];
      seq_dbg_exp = ref_mem[10'h2BB];
      seq_mode = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0AA;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h2BB;
      repeat (30) @(posedge clk);
      #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      seq_mode = 1'b0;
      chk("t3_grant_count", 32'(seq_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < seq_log.size(); i++) begin
         chk($sformatf("t3_grant_%0d", i), 32'(seq_log[i]),
             32'((i % 5 == 4) ? SEL_DBG : SEL_CPU));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
